count_stream_checker: RTL
=========================

Name: count_stream_checker

Overview:
- Receive-side monitor for the half-rate 8-bit counter stream produced by the Q4 counter circuit.
- Samples the counter value on every clk edge and checks three things: each value is held for exactly HOLD_CYCLES clocks, each new value is the previous one plus 1 (mod 2^WIDTH), and a jump to 0 is a counter restart.
- Reports lock status, error pulses, a sticky error flag and a saturating error count.
- Sits on the counter's output bus as a self-check block for lab and midterm benches.

Parameters:
- WIDTH, 8, width of monitored counter value.
- HOLD_CYCLES, 2, clk cycles each counter value must persist (divide-by-2 source clock).
- LOCK_COUNT, 4, consecutive valid increments required to enter LOCKED.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-high reset.
- cct_input  input  WIDTH  monitored counter value.
- cct_output  output  WIDTH  last accepted (validated) counter value.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per detected error in LOCKED.
- err_sticky  output  1  set on any error; cleared only by clear.
- restart_pulse  output  1  one-cycle pulse when a restart (jump to 0) is detected.
- err_count  output  8  saturating error count; holds at 255.

Behaviour:
- Reset: clear is asynchronous and active-high. While clear is high, all registers are 0 and state is SEARCH. All outputs reset to 0.
- Input stage:
  - in_q <= cct_input every edge; prev_q <= in_q.
  - change = (in_q != prev_q).
  - hold_cnt: set to 1 on change; otherwise increments, saturating at HOLD_CYCLES+1.
- Latency: a value sampled into in_q at edge N is judged at edge N+1. All outputs are registered and visible after edge N+1.
- On each change, the value is valid if in_q == expected AND the hold_cnt of the old value == HOLD_CYCLES.
- States:
  - SEARCH: ignores data until the first change. On change: expected <= in_q+1, good_cnt <= 0, go to ACQUIRE.
  - ACQUIRE, on change:
    - valid: good_cnt++, cct_output <= in_q, expected <= in_q+1. If good_cnt reaches LOCK_COUNT, go to LOCKED.
    - invalid: resync with expected <= in_q+1 and good_cnt <= 0, stay in ACQUIRE. No error is reported in ACQUIRE.
  - LOCKED:
    - valid change: cct_output <= in_q, expected <= in_q+1.
    - change to 0 while expected != 0: restart_pulse, expected <= 1, good_cnt <= 0, go to ACQUIRE. Not an error.
    - any other invalid change: err_pulse, err_sticky <= 1, err_count++ (saturating), go to FAULT.
    - stall (hold_cnt reaches HOLD_CYCLES+1 with no change): same as an invalid change. Reported once.
  - FAULT: on the next change, expected <= in_q+1, good_cnt <= 0, go to ACQUIRE. No further errors are counted while in FAULT.
- Arithmetic:
  - expected is WIDTH bits and wraps, so 255->0 with expected == 0 is a valid increment, not a restart.
  - err_count saturates at 255.
- Simultaneous events: a restart takes priority over an error classification in the same cycle.
- Glitch: a value held for fewer than HOLD_CYCLES clocks is invalid even if it is numerically correct.
- Reset mid-operation: clear abandons any state immediately. err_sticky and err_count are lost.

Decomposition:
- Package count_chk_pkg:
  - state enum (SEARCH, ACQUIRE, LOCKED, FAULT);
  - default constants for HOLD_CYCLES and LOCK_COUNT;
  - ERR_MAX = 255.
- Sub-module hold_tracker:
  - contains the input register stage, change detect and saturating hold_cnt;
  - outputs in_q, change, hold_cnt.
- Top level: FSM, expected and good_cnt registers, and the output registers.

Test Plan:
- Clean stream 0,0,1,1,2,2,... (each value held 2 clks) from reset:
  - locked rises after the 4th valid increment (value 5 accepted);
  - err_sticky stays 0 and cct_output tracks the values.
- Locked at 0xFE, then 0xFE,0xFE,0xFF,0xFF,0x00,0x00,0x01:
  - wrap is accepted, locked stays 1, no restart_pulse, cct_output = 0x01.
- Locked at 0x10, then jump to 0x13:
  - one err_pulse 2 clks after the input edge; err_count = 1, err_sticky = 1, locked = 0;
  - after 4 clean increments, locked = 1 again with err_sticky still 1.
- Locked at 0x20, then cct_input held at 0x20 for 3 clks:
  - one stall error, err_count = 1;
  - no second error while the input stays stuck.
- Locked at 0x40, then jump to 0x00:
  - restart_pulse = 1, err_count unchanged, state ACQUIRE;
  - relocks after 4 increments.
- 300 injected errors, each followed by a relock:
  - err_count saturates at 255;
  - assert clear mid-stream, asynchronously, with no clk edge: all outputs 0 immediately.

Source files
------------

// File: rtl/count_chk_pkg.sv
// -----------------------------------------------------------------------------
// count_chk_pkg
// Shared types and constants for the counter-stream checker.
//   state_t          : checker FSM states (exposed on the top-level state port)
//   DEF_*            : default parameter values for the checker
//   ERR_W / ERR_MAX  : width and saturation value of the error counter
//   cnt_width()      : bits needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package count_chk_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,  // waiting for the first value change after reset
      ACQUIRE = 2'd1,  // counting consecutive good increments
      LOCKED  = 2'd2,  // stream is trusted; deviations are errors
      FAULT   = 2'd3   // error reported; waiting for the next change to resync
   } state_t;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_HOLD_CYCLES = 2;
   localparam int DEF_LOCK_COUNT  = 4;

   localparam int               ERR_W   = 8;
   localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

   // Minimum width able to represent 0..max_val (never less than 1 bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/hold_tracker.sv
// -----------------------------------------------------------------------------
// hold_tracker
// Input register stage of the counter-stream checker. Registers the monitored
// value, flags when the registered value differs from the one before it, and
// counts how many edges the current value has persisted.
//
// Ports:
//   clk       in   system clock, rising edge
//   clear     in   asynchronous active-high reset
//   sample    in   monitored counter value (raw bus)
//   in_q      out  registered sample
//   change    out  in_q differs from the previous registered sample
//   hold_cnt  out  edges the previous value persisted; valid while change is
//                  high, otherwise the running hold of the current value.
//                  Saturates at HOLD_CYCLES+1 (that value means "stalled").
// -----------------------------------------------------------------------------
module hold_tracker
   import count_chk_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   localparam int HW         = cnt_width(HOLD_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] in_q,
   output logic             change,
   output logic [HW-1:0]    hold_cnt
);

   localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   logic [WIDTH-1:0] prev_q;

   assign change = (in_q != prev_q);

   // hold_cnt restarts at 1 on the edge that consumes a change, so at the
   // next change it still holds the full persistence of the old value.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         in_q     <= '0;
         prev_q   <= '0;
         hold_cnt <= '0;
      end else begin
         in_q   <= sample;
         prev_q <= in_q;
         if (change) begin
            hold_cnt <= HOLD_ONE;
         end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
         end
      end
   end

endmodule

// File: rtl/count_stream_checker.sv
// -----------------------------------------------------------------------------
// count_stream_checker
// Receive-side monitor for a slow counter stream in which every value is held
// for HOLD_CYCLES clocks and then increments by one (mod 2^WIDTH). The block
// locks after LOCK_COUNT consecutive good increments, then flags any wrong
// value, short hold (glitch) or stall. A jump to zero while locked is taken
// as a counter restart rather than an error.
//
// A value registered at edge N is judged at edge N+1; every output below is
// a register (or decoded straight from one) and is visible after edge N+1.
//
// Ports:
//   clk            in   system clock, rising edge
//   clear          in   asynchronous active-high reset
//   cct_input      in   monitored counter value
//   cct_output     out  last accepted (validated) counter value
//   locked         out  high while in LOCKED
//   err_pulse      out  one-cycle pulse per error detected in LOCKED
//   err_sticky     out  set on any error, cleared only by clear
//   restart_pulse  out  one-cycle pulse on a detected restart (jump to 0)
//   err_count      out  saturating error count
//   state          out  current FSM state, for observation
//
// Handshake: none. The monitored bus is sampled on every clock; there is no
// valid/ready pair, each new sample is implicitly valid.
// -----------------------------------------------------------------------------
module count_stream_checker
   import count_chk_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] cct_input,
   output logic [WIDTH-1:0] cct_output,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic             restart_pulse,
   output logic [ERR_W-1:0] err_count,
   output state_t           state
);

   localparam int HW = cnt_width(HOLD_CYCLES + 1);
   localparam int GW = cnt_width(LOCK_COUNT);

   localparam logic [HW-1:0]    HOLD_OK   = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0]    HOLD_SAT  = HW'(HOLD_CYCLES + 1);
   localparam logic [GW-1:0]    GOOD_LOCK = GW'(LOCK_COUNT);
   localparam logic [GW-1:0]    GOOD_ONE  = GW'(1);
   localparam logic [WIDTH-1:0] VAL_ONE   = WIDTH'(1);
   localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

   // ---------------------------------------------------------------------
   // Input stage
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] in_q;
   logic             change;
   logic [HW-1:0]    hold_cnt;

   hold_tracker #(
      .WIDTH       (WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold (
      .clk      (clk),
      .clear    (clear),
      .sample   (cct_input),
      .in_q     (in_q),
      .change   (change),
      .hold_cnt (hold_cnt)
   );

   // ---------------------------------------------------------------------
   // Classification of the current sample
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] expected;
   logic [GW-1:0]    good_cnt;
   logic [WIDTH-1:0] in_inc;
   logic [GW-1:0]    good_inc;
   logic             value_ok;
   logic             stall;
   logic             restart_hit;

   assign in_inc   = in_q + VAL_ONE;      // wraps naturally at 2^WIDTH
   assign good_inc = good_cnt + GOOD_ONE;

   // A change is good only if the number is right AND the old value was
   // held for exactly the nominal time; a short hold (glitch) fails here.
   assign value_ok = change && (in_q == expected) && (hold_cnt == HOLD_OK);

   // hold_cnt only reaches HOLD_SAT when no change arrived in time.
   assign stall = !change && (hold_cnt == HOLD_SAT);

   // expected == 0 means a legitimate wrap, so a zero there is not a restart.
   assign restart_hit = change && (in_q == '0) && (expected != '0);

   // ---------------------------------------------------------------------
   // Next-state / next-output logic
   // ---------------------------------------------------------------------
   state_t           state_nxt;
   logic [WIDTH-1:0] expected_nxt;
   logic [GW-1:0]    good_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic             err_pulse_nxt;
   logic             err_sticky_nxt;
   logic             restart_nxt;
   logic [ERR_W-1:0] err_count_nxt;

   always_comb begin
      state_nxt      = state;
      expected_nxt   = expected;
      good_nxt       = good_cnt;
      out_nxt        = cct_output;
      err_pulse_nxt  = 1'b0;
      err_sticky_nxt = err_sticky;
      restart_nxt    = 1'b0;
      err_count_nxt  = err_count;

      case (state)
         SEARCH: begin
            if (change) begin
               expected_nxt = in_inc;
               good_nxt     = '0;
               state_nxt    = ACQUIRE;
            end
         end

         ACQUIRE: begin
            if (change) begin
               expected_nxt = in_inc;
               if (value_ok) begin
                  good_nxt = good_inc;
                  out_nxt  = in_q;
                  if (good_inc == GOOD_LOCK) begin
                     state_nxt = LOCKED;
                  end
               end else begin
                  // Silent resync: errors are only reported once locked.
                  good_nxt = '0;
               end
            end
         end

         LOCKED: begin
            // Restart is checked first so it wins over the error path.
            if (restart_hit) begin
               restart_nxt  = 1'b1;
               expected_nxt = VAL_ONE;
               good_nxt     = '0;
               state_nxt    = ACQUIRE;
            end else if (value_ok) begin
               out_nxt      = in_q;
               expected_nxt = in_inc;
            end else if (change || stall) begin
               err_pulse_nxt  = 1'b1;
               err_sticky_nxt = 1'b1;
               if (err_count != ERR_MAX) begin
                  err_count_nxt = err_count + ERR_ONE;
               end
               state_nxt = FAULT;
            end
         end

         FAULT: begin
            // A stalled bus keeps hold_cnt saturated here; leaving LOCKED on
            // the first report is what keeps it to a single error.
            if (change) begin
               expected_nxt = in_inc;
               good_nxt     = '0;
               state_nxt    = ACQUIRE;
            end
         end

         default: begin
            state_nxt = SEARCH;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state         <= SEARCH;
         expected      <= '0;
         good_cnt      <= '0;
         cct_output    <= '0;
         err_pulse     <= 1'b0;
         err_sticky    <= 1'b0;
         restart_pulse <= 1'b0;
         err_count     <= '0;
      end else begin
         state         <= state_nxt;
         expected      <= expected_nxt;
         good_cnt      <= good_nxt;
         cct_output    <= out_nxt;
         err_pulse     <= err_pulse_nxt;
         err_sticky    <= err_sticky_nxt;
         restart_pulse <= restart_nxt;
         err_count     <= err_count_nxt;
      end
   end

   assign locked = (state == LOCKED);

endmodule
